eth_tx_sched: RTL and testbench

Frame-level scheduler that shares the Ethernet TX FIFO write port between two byte-stream sources. Grants whole frames in round-robin order, admits a frame only when the FIFO has room for a maximum-length frame, and packs the end-of-frame marker into bit 8 of the FIFO word. Frames longer than the limit are truncated and their tail discarded. Sits in the DDR clock domain, directly upstream of the TX FIFO write side.

---
 rtl/eth_tx_sched_if.sv | 11 +
 rtl/eth_tx_sched.sv | 146 ++++++++++++++
 tb/tb_eth_tx_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_sched_if.sv
// eth_tx_sched_if: byte-stream handshake bundle. It carries one source
// stream (DW=8) or the FIFO write stream (DW=9, bit 8 = end of frame).
interface eth_tx_sched_if #(parameter int DW = 8);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: frame-level round-robin scheduler for the Ethernet TX FIFO
// write port. A frame is admitted only when the FIFO has room for a MAX_LEN
// frame. Frames longer than MAX_LEN are cut, and the rest of the frame is
// drained and dropped. The end-of-frame flag travels in FIFO bit 8.
// Optional macro ETH_TX_SCHED_STATS_EN adds the frame and truncation counters.
module eth_tx_sched #(
  parameter int MAX_LEN    = 1500,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic                  clk,
  input  logic                  rst_n,
  eth_tx_sched_if.slave         s0_axis,
  eth_tx_sched_if.slave         s1_axis,
  eth_tx_sched_if.master        m_fifo_axis,
  input  logic [10:0]           fifo_wr_data_count,
  output logic                  busy,
  output logic                  grant,
  output logic                  trunc_err
`ifdef ETH_TX_SCHED_STATS_EN
  ,
  output logic [15:0]           frames0,
  output logic [15:0]           frames1,
  output logic [7:0]            trunc_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_e;

  localparam logic [10:0] CNT_MAX   = 11'(MAX_LEN - 1);
  localparam logic [11:0] MAX_LEN12 = 12'(MAX_LEN);
  localparam logic [11:0] DEPTH12   = 12'(FIFO_DEPTH);

  state_e      state_q;
  logic        last_q, grant_q, busy_q, trunc_q;
  logic [10:0] cnt_q;

  logic [11:0] free;
  logic        room, req0, req1, gnt_d;
  logic        sel_vld, sel_last, sel_rdy, at_max, acc, done, trunc_ev;
  logic [7:0]  sel_data;

  // Admission: free space is only looked at while idle, so a granted frame
  // always has its MAX_LEN headroom.
  assign free  = DEPTH12 - {1'b0, fifo_wr_data_count};
  assign room  = free >= MAX_LEN12;
  assign req0  = s0_axis.tvalid;
  assign req1  = s1_axis.tvalid;
  // A tie goes to the source that was not served last.
  assign gnt_d = (req0 && req1) ? ~last_q : req1;

  assign sel_vld  = grant_q ? s1_axis.tvalid : s0_axis.tvalid;
  assign sel_last = grant_q ? s1_axis.tlast  : s0_axis.tlast;
  assign sel_data = grant_q ? s1_axis.tdata  : s0_axis.tdata;
  assign at_max   = (cnt_q == CNT_MAX);

  // Zero-latency routing of the granted source. DROP sinks bytes locally.
  always_comb begin
    m_fifo_axis.tdata  = '0;
    m_fifo_axis.tvalid = 1'b0;
    sel_rdy            = 1'b0;
    unique case (state_q)
      PASS: begin
        m_fifo_axis.tdata  = {sel_last | at_max, sel_data};
        m_fifo_axis.tvalid = sel_vld;
        sel_rdy            = m_fifo_axis.tready;
      end
      DROP:    sel_rdy = 1'b1;
      default: ;
    endcase
  end

  assign m_fifo_axis.tlast = m_fifo_axis.tdata[8];
  assign s0_axis.tready    = sel_rdy & ~grant_q;
  assign s1_axis.tready    = sel_rdy &  grant_q;

  assign acc      = sel_vld & sel_rdy;
  assign done     = acc & sel_last;
  assign trunc_ev = (state_q == PASS) & acc & ~sel_last & at_max;

  assign busy      = busy_q;
  assign grant     = grant_q;
  assign trunc_err = trunc_q;

  // Scheduler FSM: arbitrate in IDLE, forward in PASS, discard the tail in DROP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
      trunc_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (room && (req0 || req1)) begin
            grant_q <= gnt_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= PASS;
          end
        end
        PASS: begin
          if (acc) begin
            cnt_q <= cnt_q + 11'd1;
            if (sel_last) begin
              last_q  <= grant_q;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else if (at_max) begin
              trunc_q <= 1'b1;
              state_q <= DROP;
            end
          end
        end
        DROP: begin
          if (done) begin
            last_q  <= grant_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ETH_TX_SCHED_STATS_EN
  // Wrapping statistics. Each counter steps on the same edge as the state exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames0   <= '0;
      frames1   <= '0;
      trunc_cnt <= '0;
    end else begin
      if (done && !grant_q) frames0 <= frames0 + 16'd1;
      if (done &&  grant_q) frames1 <= frames1 + 16'd1;
      if (trunc_ev)         trunc_cnt <= trunc_cnt + 8'd1;
    end
  end
`else
  logic unused_trunc_ev;
  assign unused_trunc_ev = trunc_ev;
`endif

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: randomized scenario bench for eth_tx_sched. Expected FIFO
// contents are rebuilt from the frames each source sends: truncate to MAX_LEN,
// mark the final kept byte, and place frames in round-robin order.
module tb_eth_tx_sched;
  localparam int MAX_LEN    = 1500;
  localparam int FIFO_DEPTH = 2048;

  typedef logic [7:0] bq_t[$];
  typedef logic [8:0] wq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_tx_sched_if #(.DW(8)) s0_if ();
  eth_tx_sched_if #(.DW(8)) s1_if ();
  eth_tx_sched_if #(.DW(9)) m_if ();

  logic [7:0]  s_data [2];
  logic        s_vld  [2];
  logic        s_last [2];
  logic        m_rdy;
  logic [10:0] fcnt;
  logic        busy, grant, trunc_err;

  assign s0_if.tdata  = s_data[0];
  assign s0_if.tvalid = s_vld[0];
  assign s0_if.tlast  = s_last[0];
  assign s1_if.tdata  = s_data[1];
  assign s1_if.tvalid = s_vld[1];
  assign s1_if.tlast  = s_last[1];
  assign m_if.tready  = m_rdy;

`ifdef ETH_TX_SCHED_STATS_EN
  logic [15:0] frames0, frames1;
  logic [7:0]  trunc_cnt;
`endif

  eth_tx_sched #(.MAX_LEN(MAX_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s0_axis            (s0_if),
    .s1_axis            (s1_if),
    .m_fifo_axis        (m_if),
    .fifo_wr_data_count (fcnt),
    .busy               (busy),
    .grant              (grant),
    .trunc_err          (trunc_err)
`ifdef ETH_TX_SCHED_STATS_EN
    ,
    .frames0            (frames0),
    .frames1            (frames1),
    .trunc_cnt          (trunc_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // FIFO write log: the word, the grant seen with it, and the cycle it was written in.
  logic [8:0] wr_d[$];
  logic       wr_g[$];
  int         wr_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n === 1'b1 && m_if.tvalid === 1'b1 && m_rdy === 1'b1) begin
      wr_d.push_back(m_if.tdata);
      wr_g.push_back(grant);
      wr_c.push_back(cyc);
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bq_t rand_frame(input int len);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // The FIFO holds at most MAX_LEN bytes of a frame. The last byte kept is marked.
  function automatic wq_t fifo_image(input bq_t f);
    wq_t w;
    int n;
    n = (f.size() > MAX_LEN) ? MAX_LEN : f.size();
    for (int i = 0; i < n; i++) w.push_back({(i == n - 1), f[i]});
    return w;
  endfunction

  task automatic clear_log();
    wr_d.delete(); wr_g.delete(); wr_c.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin s_vld[i] = 0; s_last[i] = 0; s_data[i] = '0; end
    m_rdy = 1'b1;
    fcnt  = '0;
    repeat (3) @(posedge clk);
    #1;
    clear_log();
    rst_n = 1'b1;
  endtask

  // Drive one frame on a source. Each call starts 1 time unit after a rising edge.
  // Up to gapmax idle cycles are inserted before each byte.
  task automatic send(input int src, input bq_t f, input int gapmax);
    int  n, g;
    bit  acc;
    for (int i = 0; i < f.size(); i++) begin
      if (gapmax > 0) begin
        g = $urandom_range(gapmax, 0);
        if (g > 0) begin
          s_vld[src] = 1'b0;
          repeat (g) begin @(posedge clk); #1; end
        end
      end
      s_data[src] = f[i];
      s_last[src] = (i == f.size() - 1);
      s_vld[src]  = 1'b1;
      n = 0;
      acc = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_vld[src] && ((src == 1) ? s1_if.tready : s0_if.tready);
        @(posedge clk); #1;
        n++;
        if (!acc && n > 5000) begin
          checks++; errors++;
          $display("FAIL send_timeout src=%0d byte=%0d: no accept within 5000 cycles", src, i);
          s_vld[src] = 1'b0;
          s_last[src] = 1'b0;
          return;
        end
      end
    end
    s_vld[src]  = 1'b0;
    s_last[src] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant !== 1'b0)      begin errors++; $display("FAIL reset_grant got=%b exp=0", grant); end
    checks++; if (trunc_err !== 1'b0)  begin errors++; $display("FAIL reset_trunc got=%b exp=0", trunc_err); end
    checks++; if (s0_if.tready !== 1'b0 || s1_if.tready !== 1'b0)
      begin errors++; $display("FAIL reset_tready got=%b%b exp=00", s0_if.tready, s1_if.tready); end
    checks++; if (m_if.tvalid !== 1'b0 || m_if.tdata !== 9'h0)
      begin errors++; $display("FAIL reset_m got=v%b d%h exp=v0 d000", m_if.tvalid, m_if.tdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bq_t f;
    wq_t e;
    int c0;
    do_reset();
    f = rand_frame(64);
    e = fifo_image(f);
    c0 = cyc;
    send(0, f, 0);
    // Now 1 time unit past the edge that accepted tlast, so busy must already be low.
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop got=%b exp=0", busy); end
    checks++; if (wr_d.size() != 64) begin errors++; $display("FAIL single_count got=%0d exp=64", wr_d.size()); end
    checks++; if (wr_c.size() > 0 && wr_c[0] != c0 + 1)
      begin errors++; $display("FAIL single_latency got=%0d exp=%0d", wr_c.size() > 0 ? wr_c[0] : -1, c0 + 1); end
    for (int i = 0; i < wr_d.size() && i < e.size(); i++) begin
      checks++;
      if (wr_d[i] !== e[i] || wr_g[i] !== 1'b0)
        begin errors++; $display("FAIL single_word[%0d] got=%h/g%b exp=%h/g0", i, wr_d[i], wr_g[i], e[i]); end
    end
  endtask

  task automatic test_round_robin();
    bq_t a[3], b[3];
    wq_t e, w;
    logic eg[$];
    do_reset();
    for (int k = 0; k < 3; k++) begin a[k] = rand_frame(10); b[k] = rand_frame(10); end
    // Both sources always have a frame waiting, so grants must alternate starting with source 0.
    for (int k = 0; k < 3; k++) begin
      w = fifo_image(a[k]); foreach (w[i]) begin e.push_back(w[i]); eg.push_back(1'b0); end
      w = fifo_image(b[k]); foreach (w[i]) begin e.push_back(w[i]); eg.push_back(1'b1); end
    end
    fork
      begin for (int k = 0; k < 3; k++) send(0, a[k], 0); end
      begin for (int k = 0; k < 3; k++) send(1, b[k], 0); end
    join
    @(posedge clk); #1;
    checks++; if (wr_d.size() != 60) begin errors++; $display("FAIL rr_count got=%0d exp=60", wr_d.size()); end
    for (int i = 0; i < wr_d.size() && i < 60; i++) begin
      checks++;
      if (wr_d[i] !== e[i] || wr_g[i] !== eg[i])
        begin errors++; $display("FAIL rr_word[%0d] got=%h/g%b exp=%h/g%b", i, wr_d[i], wr_g[i], e[i], eg[i]); end
      if (i > 0) begin
        checks++;
        if (wr_c[i] - wr_c[i-1] != ((i % 10 == 0) ? 2 : 1))
          begin errors++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", i, wr_c[i] - wr_c[i-1], (i % 10 == 0) ? 2 : 1); end
      end
    end
  endtask

  task automatic test_backpressure();
    bq_t f;
    wq_t e;
    do_reset();
    f = rand_frame(8);
    e = fifo_image(f);
    fcnt = 11'd600;
    fork
      send(1, f, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (busy !== 1'b0 || s1_if.tready !== 1'b0)
            begin errors++; $display("FAIL bp_hold got=busy%b rdy%b exp=busy0 rdy0", busy, s1_if.tready); end
        end
        @(posedge clk); #1;
        fcnt = 11'd548;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_early got=%b exp=0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || grant !== 1'b1)
          begin errors++; $display("FAIL bp_grant got=busy%b g%b exp=busy1 g1", busy, grant); end
      end
    join
    fcnt = '0;
    checks++; if (wr_d.size() != 8) begin errors++; $display("FAIL bp_count got=%0d exp=8", wr_d.size()); end
    for (int i = 0; i < wr_d.size() && i < 8; i++) begin
      checks++;
      if (wr_d[i] !== e[i] || wr_g[i] !== 1'b1)
        begin errors++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, wr_d[i], e[i]); end
    end
  endtask

  task automatic test_truncation();
    bq_t f, g;
    wq_t e, w;
    logic eg[$];
    do_reset();
    f = rand_frame(1600);
    g = rand_frame(5);
    w = fifo_image(f); foreach (w[i]) begin e.push_back(w[i]); eg.push_back(1'b0); end
    w = fifo_image(g); foreach (w[i]) begin e.push_back(w[i]); eg.push_back(1'b1); end
    send(0, f, 0);
    checks++; if (trunc_err !== 1'b1) begin errors++; $display("FAIL trunc_flag got=%b exp=1", trunc_err); end
    send(1, g, 0);
    @(posedge clk); #1;
    checks++; if (wr_d.size() != MAX_LEN + 5)
      begin errors++; $display("FAIL trunc_count got=%0d exp=%0d", wr_d.size(), MAX_LEN + 5); end
    for (int i = 0; i < wr_d.size() && i < e.size(); i++) begin
      checks++;
      if (wr_d[i] !== e[i] || wr_g[i] !== eg[i])
        begin errors++; $display("FAIL trunc_word[%0d] got=%h/g%b exp=%h/g%b", i, wr_d[i], wr_g[i], e[i], eg[i]); end
    end
    checks++; if (trunc_err !== 1'b1) begin errors++; $display("FAIL trunc_sticky got=%b exp=1", trunc_err); end
  endtask

  task automatic test_throttle();
    bq_t f;
    wq_t e;
    bit done;
    do_reset();
    f = rand_frame(200);
    e = fifo_image(f);
    done = 0;
    fork
      begin send(0, f, 2); done = 1; end
      begin
        while (!done) begin @(posedge clk); #1; m_rdy = 1'($urandom_range(1, 0)); end
        m_rdy = 1'b1;
      end
    join
    checks++; if (wr_d.size() != 200) begin errors++; $display("FAIL thr_count got=%0d exp=200", wr_d.size()); end
    for (int i = 0; i < wr_d.size() && i < 200; i++) begin
      checks++;
      if (wr_d[i] !== e[i]) begin errors++; $display("FAIL thr_word[%0d] got=%h exp=%h", i, wr_d[i], e[i]); end
    end
  endtask

  task automatic test_random_mix();
    bq_t f0[6], f1[6];
    wq_t e[2], w, act[2];
    bit d0, d1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      f0[k] = rand_frame($urandom_range(40, 1));
      f1[k] = rand_frame($urandom_range(40, 1));
      w = fifo_image(f0[k]); foreach (w[i]) e[0].push_back(w[i]);
      w = fifo_image(f1[k]); foreach (w[i]) e[1].push_back(w[i]);
    end
    d0 = 0; d1 = 0;
    fork
      begin for (int k = 0; k < 6; k++) send(0, f0[k], 2); d0 = 1; end
      begin for (int k = 0; k < 6; k++) send(1, f1[k], 2); d1 = 1; end
      begin
        while (!(d0 && d1)) begin @(posedge clk); #1; m_rdy = ($urandom_range(3, 0) != 0); end
        m_rdy = 1'b1;
      end
    join
    // Split the write log by source. A change of source must only follow an end-of-frame word.
    for (int i = 0; i < wr_d.size(); i++) begin
      act[wr_g[i]].push_back(wr_d[i]);
      if (i > 0 && wr_g[i] != wr_g[i-1]) begin
        checks++;
        if (wr_d[i-1][8] !== 1'b1) begin errors++; $display("FAIL mix_interleave at %0d got_eof=%b exp=1", i, wr_d[i-1][8]); end
      end
    end
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (act[s].size() != e[s].size())
        begin errors++; $display("FAIL mix_count src%0d got=%0d exp=%0d", s, act[s].size(), e[s].size()); end
      for (int i = 0; i < act[s].size() && i < e[s].size(); i++) begin
        checks++;
        if (act[s][i] !== e[s][i]) begin errors++; $display("FAIL mix_word src%0d[%0d] got=%h exp=%h", s, i, act[s][i], e[s][i]); end
      end
    end
  endtask

  // Runs straight after the truncation test, so trunc_err starts out set and reset must clear it.
  task automatic test_reset_mid();
    bq_t a, b;
    int n;
    clear_log();
    m_rdy = 1'b1;
    s_data[1] = 8'h5A; s_last[1] = 1'b0; s_vld[1] = 1'b1;
    n = 0;
    while (wr_d.size() < 30 && n < 200) begin @(negedge clk); n++; end
    checks++; if (wr_d.size() < 30) begin errors++; $display("FAIL rmid_progress got=%0d exp=30", wr_d.size()); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || grant !== 1'b0 || trunc_err !== 1'b0)
      begin errors++; $display("FAIL rmid_regs got=busy%b g%b te%b exp=000", busy, grant, trunc_err); end
    checks++; if (s0_if.tready !== 1'b0 || s1_if.tready !== 1'b0 || m_if.tvalid !== 1'b0 || m_if.tdata !== 9'h0)
      begin errors++; $display("FAIL rmid_ports got=r%b%b v%b d%h exp=r00 v0 d000", s0_if.tready, s1_if.tready, m_if.tvalid, m_if.tdata); end
    s_vld[1] = 1'b0;
    @(posedge clk); #1;
    clear_log();
    rst_n = 1'b1;
    a = rand_frame(2);
    b = rand_frame(2);
    fork
      send(0, a, 0);
      send(1, b, 0);
    join
    @(posedge clk); #1;
    checks++; if (wr_g.size() != 4) begin errors++; $display("FAIL rmid_count got=%0d exp=4", wr_g.size()); end
    checks++; if (wr_g.size() > 0 && wr_g[0] !== 1'b0)
      begin errors++; $display("FAIL rmid_first_grant got=%b exp=0", wr_g[0]); end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin s_vld[i] = 0; s_last[i] = 0; s_data[i] = '0; end
    m_rdy = 1'b1;
    fcnt  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_throttle();
    test_random_mix();
    test_truncation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
